// File: rtl/branch_station.sv
`default_nettype none
// ============================================================================
// Module      : branch_station
// Description : Branch/jump reservation station. Holds up to RS_DEPTH
//               JAL/JALR/Bxx ops, wakes their operands from CDB_PORTS
//               common-data-bus channels and issues the oldest ready op,
//               resolving direction, target and link value in one step.
//
//   Ports
//     clk_in, rst_in        clock (posedge), asynchronous active-high reset
//     rdy_in                0 = global stall, every register holds
//     flush_in              invalidates every entry at the next edge
//     in_valid .. in_vk     dispatch channel (tag, op, pc, imm, q/v operands)
//     full_out              every entry is occupied
//     cdb_valid/tag/value   flattened broadcast channels, channel k at [k*W +: W]
//     out_valid .. out_link registered one-cycle branch result
//
//   Optional build macro BR_PREDICT_EN adds in_pred_taken (stored per entry)
//   and out_mispredict = (out_taken != predicted) | JALR.
//
//   Op encoding (in_op): JAL=1 JALR=2 BEQ=3 BNE=4 BLT=5 BGE=6 BLTU=7 BGEU=8;
//   any other value is dropped at dispatch.
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_station #(
    parameter int RS_DEPTH  = 8,
    parameter int TAG_W     = 5,
    parameter int XLEN      = 32,
    parameter int CDB_PORTS = 3
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       in_valid,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [10:0]                in_op,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [TAG_W-1:0]           in_qj,
    input  logic [TAG_W-1:0]           in_qk,
    input  logic [XLEN-1:0]            in_vj,
    input  logic [XLEN-1:0]            in_vk,
    output logic                       full_out,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_value,
    output logic                       out_valid,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_taken,
    output logic [XLEN-1:0]            out_target,
    output logic [XLEN-1:0]            out_link
`ifdef BR_PREDICT_EN
    ,
    input  logic                       in_pred_taken,
    output logic                       out_mispredict
`endif
);

    localparam int         c_IDX_W   = $clog2(RS_DEPTH);
    localparam logic [10:0] c_OP_JAL  = 11'd1;
    localparam logic [10:0] c_OP_JALR = 11'd2;
    localparam logic [10:0] c_OP_BEQ  = 11'd3;
    localparam logic [10:0] c_OP_BNE  = 11'd4;
    localparam logic [10:0] c_OP_BLT  = 11'd5;
    localparam logic [10:0] c_OP_BGE  = 11'd6;
    localparam logic [10:0] c_OP_BLTU = 11'd7;
    localparam logic [10:0] c_OP_BGEU = 11'd8;

    // Entry storage
    logic [RS_DEPTH-1:0] r_valid;
    logic [10:0]         r_op  [RS_DEPTH];
    logic [TAG_W-1:0]    r_tag [RS_DEPTH];
    logic [XLEN-1:0]     r_pc  [RS_DEPTH];
    logic [XLEN-1:0]     r_imm [RS_DEPTH];
    logic [TAG_W-1:0]    r_qj  [RS_DEPTH];
    logic [TAG_W-1:0]    r_qk  [RS_DEPTH];
    logic [XLEN-1:0]     r_vj  [RS_DEPTH];
    logic [XLEN-1:0]     r_vk  [RS_DEPTH];
    logic [RS_DEPTH-1:0] r_pred;
    // r_age[i][j] = 1 : entry i is older than entry j
    logic [RS_DEPTH-1:0] r_age [RS_DEPTH];

    assign full_out = &r_valid;

    // ---------------------------------------------------------------- dispatch
    logic               w_op_known;
    logic               w_alloc;
    logic [c_IDX_W-1:0] w_free_idx;
    logic [TAG_W-1:0]   w_new_qj, w_new_qk;
    logic [XLEN-1:0]    w_new_vj, w_new_vk;

    assign w_op_known = (in_op >= c_OP_JAL) && (in_op <= c_OP_BGEU);
    assign w_alloc    = in_valid && !full_out && w_op_known;

    always_comb begin
        w_free_idx = '0;
        // Descending scan leaves the lowest free index
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = c_IDX_W'(i);
        end
    end

    // Operand capture at dispatch, including same-cycle CDB bypass.
    // Channels are scanned high to low so the lowest matching channel wins.
    always_comb begin
        w_new_qj = in_qj;
        w_new_vj = in_vj;
        w_new_qk = in_qk;
        w_new_vk = in_vk;
        if (in_op == c_OP_JAL) begin
            w_new_qj = '0;
        end else if (in_qj != '0) begin
            for (int k = CDB_PORTS - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == in_qj) begin
                    w_new_qj = '0;
                    w_new_vj = cdb_value[k*XLEN +: XLEN];
                end
            end
        end
        if (in_op == c_OP_JAL || in_op == c_OP_JALR) begin
            w_new_qk = '0;
        end else if (in_qk != '0) begin
            for (int k = CDB_PORTS - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == in_qk) begin
                    w_new_qk = '0;
                    w_new_vk = cdb_value[k*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------ wakeup
    logic [TAG_W-1:0] w_qj_nxt [RS_DEPTH];
    logic [TAG_W-1:0] w_qk_nxt [RS_DEPTH];
    logic [XLEN-1:0]  w_vj_nxt [RS_DEPTH];
    logic [XLEN-1:0]  w_vk_nxt [RS_DEPTH];

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_qj_nxt[i] = r_qj[i];
            w_vj_nxt[i] = r_vj[i];
            w_qk_nxt[i] = r_qk[i];
            w_vk_nxt[i] = r_vk[i];
            for (int k = CDB_PORTS - 1; k >= 0; k--) begin
                if (r_qj[i] != '0 && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == r_qj[i]) begin
                    w_qj_nxt[i] = '0;
                    w_vj_nxt[i] = cdb_value[k*XLEN +: XLEN];
                end
                if (r_qk[i] != '0 && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == r_qk[i]) begin
                    w_qk_nxt[i] = '0;
                    w_vk_nxt[i] = cdb_value[k*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------- issue
    logic [RS_DEPTH-1:0] w_ready;
    logic [RS_DEPTH-1:0] w_sel;

    // An entry is selected when no other ready entry is older than it; the age
    // matrix is a total order over valid entries, so w_sel is one-hot or zero.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ready[i] = r_valid[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_sel[i] = w_ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && w_ready[j] && r_age[j][i]) w_sel[i] = 1'b0;
            end
        end
    end

    logic [10:0]      w_sel_op;
    logic [TAG_W-1:0] w_sel_tag;
    logic [XLEN-1:0]  w_sel_pc, w_sel_imm, w_sel_vj, w_sel_vk;
    logic             w_sel_pred;

    always_comb begin
        w_sel_op   = '0;
        w_sel_tag  = '0;
        w_sel_pc   = '0;
        w_sel_imm  = '0;
        w_sel_vj   = '0;
        w_sel_vk   = '0;
        w_sel_pred = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_sel[i]) begin
                w_sel_op   = r_op[i];
                w_sel_tag  = r_tag[i];
                w_sel_pc   = r_pc[i];
                w_sel_imm  = r_imm[i];
                w_sel_vj   = r_vj[i];
                w_sel_vk   = r_vk[i];
                w_sel_pred = r_pred[i];
            end
        end
    end

    logic [XLEN-1:0] w_pc4, w_pc_imm, w_jalr_sum;
    logic            w_cond;
    logic            w_res_taken;
    logic [XLEN-1:0] w_res_target, w_res_link;

    assign w_pc4      = w_sel_pc + XLEN'(4);
    assign w_pc_imm   = w_sel_pc + w_sel_imm;
    assign w_jalr_sum = w_sel_vj + w_sel_imm;

    always_comb begin
        w_cond = 1'b0;
        case (w_sel_op)
            c_OP_BEQ:  w_cond = (w_sel_vj == w_sel_vk);
            c_OP_BNE:  w_cond = (w_sel_vj != w_sel_vk);
            c_OP_BLT:  w_cond = ($signed(w_sel_vj) <  $signed(w_sel_vk));
            c_OP_BGE:  w_cond = ($signed(w_sel_vj) >= $signed(w_sel_vk));
            c_OP_BLTU: w_cond = (w_sel_vj <  w_sel_vk);
            c_OP_BGEU: w_cond = (w_sel_vj >= w_sel_vk);
            default:   w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_res_taken  = w_cond;
        w_res_target = w_cond ? w_pc_imm : w_pc4;
        w_res_link   = '0;
        if (w_sel_op == c_OP_JAL) begin
            w_res_taken  = 1'b1;
            w_res_target = w_pc_imm;
            w_res_link   = w_pc4;
        end else if (w_sel_op == c_OP_JALR) begin
            w_res_taken  = 1'b1;
            w_res_target = w_jalr_sum & ~XLEN'(1);
            w_res_link   = w_pc4;
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid    <= '0;
            r_pred     <= '0;
            out_valid  <= 1'b0;
            out_tag    <= '0;
            out_taken  <= 1'b0;
            out_target <= '0;
            out_link   <= '0;
`ifdef BR_PREDICT_EN
            out_mispredict <= 1'b0;
`endif
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_op[i]  <= '0;
                r_tag[i] <= '0;
                r_pc[i]  <= '0;
                r_imm[i] <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_age[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                r_valid   <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= |w_sel;
                if (|w_sel) begin
                    out_tag    <= w_sel_tag;
                    out_taken  <= w_res_taken;
                    out_target <= w_res_target;
                    out_link   <= w_res_link;
`ifdef BR_PREDICT_EN
                    out_mispredict <= (w_res_taken != w_sel_pred) || (w_sel_op == c_OP_JALR);
`endif
                end
                for (int i = 0; i < RS_DEPTH; i++) begin
                    r_qj[i] <= w_qj_nxt[i];
                    r_vj[i] <= w_vj_nxt[i];
                    r_qk[i] <= w_qk_nxt[i];
                    r_vk[i] <= w_vk_nxt[i];
                    if (w_sel[i]) r_valid[i] <= 1'b0;
                end
                // The allocated slot was invalid, so these writes never collide
                // with the issue clear or a wakeup of live data above.
                if (w_alloc) begin
                    r_valid[w_free_idx] <= 1'b1;
                    r_op[w_free_idx]    <= in_op;
                    r_tag[w_free_idx]   <= in_tag;
                    r_pc[w_free_idx]    <= in_pc;
                    r_imm[w_free_idx]   <= in_imm;
                    r_qj[w_free_idx]    <= w_new_qj;
                    r_vj[w_free_idx]    <= w_new_vj;
                    r_qk[w_free_idx]    <= w_new_qk;
                    r_vk[w_free_idx]    <= w_new_vk;
`ifdef BR_PREDICT_EN
                    r_pred[w_free_idx]  <= in_pred_taken;
`endif
                    r_age[w_free_idx]   <= '0;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        if (c_IDX_W'(j) != w_free_idx) r_age[j][w_free_idx] <= 1'b1;
                    end
                end
            end
        end
    end

`ifndef BR_PREDICT_EN
    // Prediction storage exists only in the predicting build
    logic w_unused_pred;
    assign w_unused_pred = w_sel_pred;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_station
// Description : Directed self-checking bench for branch_station: reset state,
//               branch/jump resolution, CDB wakeup and bypass, full handling,
//               age ordering, flush, stall and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_station;

    localparam int c_DEPTH = 8;
    localparam int c_TAG_W = 5;
    localparam int c_XLEN  = 32;
    localparam int c_PORTS = 3;

    localparam logic [10:0] c_JAL  = 11'd1;
    localparam logic [10:0] c_JALR = 11'd2;
    localparam logic [10:0] c_BEQ  = 11'd3;
    localparam logic [10:0] c_BNE  = 11'd4;
    localparam logic [10:0] c_BLT  = 11'd5;
    localparam logic [10:0] c_BGE  = 11'd6;
    localparam logic [10:0] c_BLTU = 11'd7;
    localparam logic [10:0] c_BGEU = 11'd8;

    logic                          clk_in = 1'b0;
    logic                          rst_in;
    logic                          rdy_in;
    logic                          flush_in;
    logic                          in_valid;
    logic [c_TAG_W-1:0]            in_tag;
    logic [10:0]                   in_op;
    logic [c_XLEN-1:0]             in_pc, in_imm, in_vj, in_vk;
    logic [c_TAG_W-1:0]            in_qj, in_qk;
    logic                          full_out;
    logic [c_PORTS-1:0]            cdb_valid;
    logic [c_PORTS*c_TAG_W-1:0]    cdb_tag;
    logic [c_PORTS*c_XLEN-1:0]     cdb_value;
    logic                          out_valid;
    logic [c_TAG_W-1:0]            out_tag;
    logic                          out_taken;
    logic [c_XLEN-1:0]             out_target, out_link;
`ifdef BR_PREDICT_EN
    logic                          in_pred_taken;
    logic                          out_mispredict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    branch_station #(
        .RS_DEPTH (c_DEPTH),
        .TAG_W    (c_TAG_W),
        .XLEN     (c_XLEN),
        .CDB_PORTS(c_PORTS)
    ) u_dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .in_op     (in_op),
        .in_pc     (in_pc),
        .in_imm    (in_imm),
        .in_qj     (in_qj),
        .in_qk     (in_qk),
        .in_vj     (in_vj),
        .in_vk     (in_vk),
        .full_out  (full_out),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_taken (out_taken),
        .out_target(out_target),
        .out_link  (out_link)
`ifdef BR_PREDICT_EN
        ,
        .in_pred_taken (in_pred_taken),
        .out_mispredict(out_mispredict)
`endif
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one edge and settle just past it
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dispatch(input logic [10:0] op, input logic [c_TAG_W-1:0] tag,
                            input logic [c_XLEN-1:0] pc, input logic [c_XLEN-1:0] imm,
                            input logic [c_TAG_W-1:0] qj, input logic [c_TAG_W-1:0] qk,
                            input logic [c_XLEN-1:0] vj, input logic [c_XLEN-1:0] vk);
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = tag;
        in_pc    = pc;
        in_imm   = imm;
        in_qj    = qj;
        in_qk    = qk;
        in_vj    = vj;
        in_vk    = vk;
        step();
        in_valid = 1'b0;
    endtask

    task automatic broadcast(input int ch, input logic [c_TAG_W-1:0] tag, input logic [c_XLEN-1:0] val);
        cdb_valid[ch]                    = 1'b1;
        cdb_tag[ch*c_TAG_W +: c_TAG_W]   = tag;
        cdb_value[ch*c_XLEN +: c_XLEN]   = val;
    endtask

    task automatic cdb_idle();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_value = '0;
    endtask

    task automatic check_result(input string name, input logic [c_TAG_W-1:0] tag, input logic taken,
                                input logic [c_XLEN-1:0] target, input logic [c_XLEN-1:0] link);
        check_eq({name, ".valid"},  64'(out_valid),  64'(1));
        check_eq({name, ".tag"},    64'(out_tag),    64'(tag));
        check_eq({name, ".taken"},  64'(out_taken),  64'(taken));
        check_eq({name, ".target"}, 64'(out_target), 64'(target));
        check_eq({name, ".link"},   64'(out_link),   64'(link));
    endtask

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_tag   = '0;
        in_pc    = '0;
        in_imm   = '0;
        in_qj    = '0;
        in_qk    = '0;
        in_vj    = '0;
        in_vk    = '0;
`ifdef BR_PREDICT_EN
        in_pred_taken = 1'b0;
`endif
        cdb_idle();
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Reset state
        check_eq("rst.valid",  64'(out_valid),  64'(0));
        check_eq("rst.full",   64'(full_out),   64'(0));
        check_eq("rst.tag",    64'(out_tag),    64'(0));
        check_eq("rst.target", 64'(out_target), 64'(0));
        check_eq("rst.link",   64'(out_link),   64'(0));

        // BEQ ready at dispatch: result two edges later
        dispatch(c_BEQ, 5'd3, 32'h100, 32'h20, 5'd0, 5'd0, 32'd5, 32'd5);
        check_eq("beq.early", 64'(out_valid), 64'(0));
        step();
        check_result("beq", 5'd3, 1'b1, 32'h120, 32'h0);
        step();
        check_eq("beq.pulse", 64'(out_valid), 64'(0));

        // Signed vs unsigned compare on the same operands
        dispatch(c_BLT, 5'd4, 32'h200, 32'h40, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check_result("blt", 5'd4, 1'b1, 32'h240, 32'h0);
        dispatch(c_BLTU, 5'd5, 32'h300, 32'h40, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check_result("bltu", 5'd5, 1'b0, 32'h304, 32'h0);
        dispatch(c_BGEU, 5'd6, 32'h380, 32'h40, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check_result("bgeu", 5'd6, 1'b1, 32'h3C0, 32'h0);
        dispatch(c_BGE, 5'd7, 32'h3A0, 32'h40, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        check_result("bge", 5'd7, 1'b0, 32'h3A4, 32'h0);

        // JAL with negative immediate; its operand tags are ignored
        dispatch(c_JAL, 5'd6, 32'h400, 32'hFFFF_FFF0, 5'd9, 5'd9, 32'd0, 32'd0);
        step();
        check_result("jal", 5'd6, 1'b1, 32'h3F0, 32'h404);

        // JALR waiting on tag 7, woken by channel 2
        dispatch(c_JALR, 5'd8, 32'h500, 32'h4, 5'd7, 5'd7, 32'd0, 32'd0);
        check_eq("jalr.wait", 64'(out_valid), 64'(0));
        broadcast(2, 5'd7, 32'h203);
        step();
        cdb_idle();
        check_eq("jalr.wake", 64'(out_valid), 64'(0));
        step();
        check_result("jalr", 5'd8, 1'b1, 32'h206, 32'h504);

        // JALR same-cycle bypass; channels 0 and 1 both match, channel 0 wins
        broadcast(0, 5'd7, 32'h101);
        broadcast(1, 5'd7, 32'h203);
        dispatch(c_JALR, 5'd10, 32'h600, 32'h4, 5'd7, 5'd0, 32'd0, 32'd0);
        cdb_idle();
        step();
        check_result("jalr_byp", 5'd10, 1'b1, 32'h104, 32'h604);
        step();

        // Fill all entries waiting on tag 9
        for (int i = 0; i < c_DEPTH; i++) begin
            dispatch(c_BEQ, 5'(11 + i), 32'h1000 + 32'(16 * i), 32'h80, 5'd9, 5'd0, 32'd0, 32'(i));
        end
        check_eq("fill.full", 64'(full_out), 64'(1));
        dispatch(c_BEQ, 5'd19, 32'h2000, 32'h8, 5'd0, 5'd0, 32'd1, 32'd1);
        check_eq("fill.full2", 64'(full_out), 64'(1));
        check_eq("fill.idle", 64'(out_valid), 64'(0));
        step();
        check_eq("fill.idle2", 64'(out_valid), 64'(0));
        broadcast(0, 5'd9, 32'd3);
        step();
        cdb_idle();
        for (int i = 0; i < c_DEPTH; i++) begin
            step();
            check_eq("drain.valid",  64'(out_valid), 64'(1));
            check_eq("drain.tag",    64'(out_tag),   64'(11 + i));
            check_eq("drain.taken",  64'(out_taken), 64'(i == 3));
            check_eq("drain.target", 64'(out_target),
                     64'((i == 3) ? (32'h1000 + 32'(16 * i) + 32'h80) : (32'h1000 + 32'(16 * i) + 32'h4)));
        end
        step();
        check_eq("drain.end", 64'(out_valid), 64'(0));
        check_eq("drain.full", 64'(full_out), 64'(0));

        // Age: slot 0 refilled with a younger op than slot 1
        dispatch(c_BEQ, 5'd20, 32'h800, 32'h8, 5'd0, 5'd0, 32'd0, 32'd0);
        dispatch(c_BNE, 5'd22, 32'h810, 32'h8, 5'd23, 5'd0, 32'd0, 32'd0);
        check_eq("age.x", 64'(out_tag), 64'(20));
        dispatch(c_BNE, 5'd24, 32'h820, 32'h8, 5'd23, 5'd0, 32'd0, 32'd0);
        check_eq("age.none", 64'(out_valid), 64'(0));
        broadcast(1, 5'd23, 32'd1);
        step();
        cdb_idle();
        step();
        check_result("age.first", 5'd22, 1'b1, 32'h818, 32'h0);
        step();
        check_result("age.second", 5'd24, 1'b1, 32'h828, 32'h0);
        step();

        // Flush with a ready entry and a same-cycle dispatch
        for (int i = 0; i < 3; i++) begin
            dispatch(c_BEQ, 5'(26 + i), 32'hA00, 32'h8, 5'd25, 5'd0, 32'd0, 32'd0);
        end
        dispatch(c_BEQ, 5'd29, 32'hA00, 32'h8, 5'd0, 5'd0, 32'd0, 32'd0);
        flush_in = 1'b1;
        dispatch(c_JAL, 5'd30, 32'hB00, 32'h8, 5'd0, 5'd0, 32'd0, 32'd0);
        flush_in = 1'b0;
        check_eq("flush.valid", 64'(out_valid), 64'(0));
        check_eq("flush.full",  64'(full_out),  64'(0));
        broadcast(0, 5'd25, 32'd0);
        step();
        cdb_idle();
        for (int i = 0; i < 3; i++) begin
            check_eq("flush.quiet", 64'(out_valid), 64'(0));
            step();
        end

        // Stall freezes the outputs and blocks dispatch
        dispatch(c_BNE, 5'd31, 32'h700, 32'h10, 5'd0, 5'd0, 32'd1, 32'd2);
        step();
        check_result("stall.pre", 5'd31, 1'b1, 32'h710, 32'h0);
        rdy_in   = 1'b0;
        in_valid = 1'b1;
        in_op    = c_JAL;
        in_tag   = 5'd1;
        in_qj    = 5'd0;
        in_qk    = 5'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall.valid",  64'(out_valid),  64'(1));
            check_eq("stall.tag",    64'(out_tag),    64'(31));
            check_eq("stall.target", 64'(out_target), 64'(32'h710));
        end
        in_valid = 1'b0;
        rdy_in   = 1'b1;
        step();
        check_eq("stall.rel", 64'(out_valid), 64'(0));
        step();
        check_eq("stall.nodisp", 64'(out_valid), 64'(0));

        // Asynchronous reset between edges
        dispatch(c_JAL, 5'd2, 32'h900, 32'h10, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        check_result("arst.pre", 5'd2, 1'b1, 32'h910, 32'h904);
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("arst.valid",  64'(out_valid),  64'(0));
        check_eq("arst.tag",    64'(out_tag),    64'(0));
        check_eq("arst.target", 64'(out_target), 64'(0));
        #1;
        rst_in = 1'b0;
        step();
        check_eq("arst.after", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
